// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcode constants and FSM state encoding shared by the multi-cycle ALU.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_mc_pkg;

  // Operation codes (6-bit field as issued by the control unit)
  localparam logic [5:0] ALU_OP_ADD  = 6'h20;
  localparam logic [5:0] ALU_OP_SUB  = 6'h22;
  localparam logic [5:0] ALU_OP_MUL  = 6'h2c;
  localparam logic [5:0] ALU_OP_SRL  = 6'h02;
  localparam logic [5:0] ALU_OP_SLL  = 6'h01;
  localparam logic [5:0] ALU_OP_AND  = 6'h24;
  localparam logic [5:0] ALU_OP_OR   = 6'h25;
  localparam logic [5:0] ALU_OP_NOR  = 6'h27;
  localparam logic [5:0] ALU_OP_SLT  = 6'h2a;
  localparam logic [5:0] ALU_OP_SLTU = 6'h2b;
  localparam logic [5:0] ALU_OP_DIVU = 6'h1a;
  localparam logic [5:0] ALU_OP_REMU = 6'h1b;

  // Top-level controller states; ST_DIV is only reachable when division is built in
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: shared shift/accumulate datapath - shift-add multiply, optional restoring divide.
// Latency: loads on start_i, then DATA_WIDTH steps; done_o flags the final step with its result on acc_o/shr_o.
// Backpressure: none; busy_o is high while stepping and start_i is only issued by the owner when idle.
// Optional feature macro: ALU_MC_DIV_EN (adds div_i/shr_o and the restoring-division step).
module alu_mc_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
`ifdef ALU_MC_DIV_EN
  input  logic                  div_i,
`endif
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  busy_o,
  output logic                  done_o,
`ifdef ALU_MC_DIV_EN
  output logic [DATA_WIDTH-1:0] shr_o,
`endif
  output logic [DATA_WIDTH-1:0] acc_o
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  // acc: product accumulator / partial remainder
  // mcand: multiplicand (shifts left) / divisor (static)
  // shr: multiplier (shifts right) / dividend-becoming-quotient (shifts left)
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] shr_q, shr_d;
  logic [CW-1:0]         cnt_q;
  logic                  busy_q;
`ifdef ALU_MC_DIV_EN
  logic                  div_q;
  logic [DATA_WIDTH:0]   rem_sh;
  logic [DATA_WIDTH:0]   rem_diff;
`endif

  // One iteration of the selected algorithm, computed from the current registers
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    shr_d   = shr_q;
`ifdef ALU_MC_DIV_EN
    rem_sh   = {acc_q, shr_q[DATA_WIDTH-1]};
    rem_diff = rem_sh - {1'b0, mcand_q};
    if (div_q) begin
      // No borrow means the shifted remainder covers the divisor: subtract and set a quotient bit
      if (!rem_diff[DATA_WIDTH]) begin
        acc_d = rem_diff[DATA_WIDTH-1:0];
        shr_d = {shr_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_sh[DATA_WIDTH-1:0];
        shr_d = {shr_q[DATA_WIDTH-2:0], 1'b0};
      end
    end else
`endif
    begin
      if (shr_q[0]) acc_d = acc_q + mcand_q;
      mcand_d = mcand_q << 1;
      shr_d   = shr_q >> 1;
    end
  end

  // Load operands on start, then step once per cycle until the counter wraps
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      shr_q   <= '0;
`ifdef ALU_MC_DIV_EN
      div_q   <= 1'b0;
`endif
    end else if (start_i) begin
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      acc_q   <= '0;
`ifdef ALU_MC_DIV_EN
      div_q   <= div_i;
      mcand_q <= div_i ? b_i : a_i;
      shr_q   <= div_i ? a_i : b_i;
`else
      mcand_q <= a_i;
      shr_q   <= b_i;
`endif
    end else if (busy_q) begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      shr_q   <= shr_d;
      cnt_q   <= cnt_q + 1'b1;
      if (cnt_q == LAST) busy_q <= 1'b0;
    end
  end

  // Result of the final step is presented combinationally so the owner registers it on that same edge
  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == LAST);
  assign acc_o  = acc_d;
`ifdef ALU_MC_DIV_EN
  assign shr_o  = shr_d;
`endif

endmodule

// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU with ZERO/NEG/ERR flags; single-cycle ops inline, mul/div iterative.
// Latency: 1 cycle for single-cycle and unsupported ops; DATA_WIDTH+1 cycles accept-to-OUT_VALID for mul/div.
// Backpressure: IN_READY is low while an iterative op runs; IN_VALID is ignored until it rises again.
// Optional feature macro: ALU_MC_DIV_EN (divu/remu via restoring division; divide-by-zero completes in 1 cycle).
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int OPRN_WIDTH  = 6,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] OP1,
  input  logic [DATA_WIDTH-1:0] OP2,
  input  logic [OPRN_WIDTH-1:0] OPRN,
  output logic                  OUT_VALID,
  output logic [DATA_WIDTH-1:0] OUT,
  output logic                  ZERO,
  output logic                  NEG,
  output logic                  ERR
);

  alu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  zero_q, zero_d;
  logic                  neg_q, neg_d;
  logic                  err_q, err_d;
  logic                  vld_q, vld_d;

  logic [DATA_WIDTH-1:0] sc_res;
  logic                  sc_err;
  logic                  shift_ovf;
  logic [SHAMT_WIDTH-1:0] shamt;

  logic                  iter_start;
  logic                  iter_busy;
  logic                  iter_done;
  logic [DATA_WIDTH-1:0] iter_acc;
`ifdef ALU_MC_DIV_EN
  logic                  iter_div;
  logic [DATA_WIDTH-1:0] iter_shr;
  logic                  is_divu, is_remu;
  logic                  rem_sel_q, rem_sel_d;
  assign is_divu = (OPRN == OPRN_WIDTH'(ALU_OP_DIVU));
  assign is_remu = (OPRN == OPRN_WIDTH'(ALU_OP_REMU));
`endif

  // Any set bit above the shift-amount field means a shift of DATA_WIDTH or more
  assign shift_ovf = |OP2[DATA_WIDTH-1:SHAMT_WIDTH];
  assign shamt     = OP2[SHAMT_WIDTH-1:0];

  // Single-cycle results straight from the live request; unknown opcodes flag ERR with OUT=0
  always_comb begin
    sc_res = '0;
    sc_err = 1'b0;
    case (OPRN)
      OPRN_WIDTH'(ALU_OP_ADD):  sc_res = OP1 + OP2;
      OPRN_WIDTH'(ALU_OP_SUB):  sc_res = OP1 - OP2;
      OPRN_WIDTH'(ALU_OP_SRL):  sc_res = shift_ovf ? '0 : (OP1 >> shamt);
      OPRN_WIDTH'(ALU_OP_SLL):  sc_res = shift_ovf ? '0 : (OP1 << shamt);
      OPRN_WIDTH'(ALU_OP_AND):  sc_res = OP1 & OP2;
      OPRN_WIDTH'(ALU_OP_OR):   sc_res = OP1 | OP2;
      OPRN_WIDTH'(ALU_OP_NOR):  sc_res = ~(OP1 | OP2);
      OPRN_WIDTH'(ALU_OP_SLT):  sc_res = DATA_WIDTH'($signed(OP1) < $signed(OP2));
      OPRN_WIDTH'(ALU_OP_SLTU): sc_res = DATA_WIDTH'(OP1 < OP2);
      default:                  sc_err = 1'b1;
    endcase
  end

  alu_mc_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_iter (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .start_i (iter_start),
`ifdef ALU_MC_DIV_EN
    .div_i   (iter_div),
`endif
    .a_i     (OP1),
    .b_i     (OP2),
    .busy_o  (iter_busy),
    .done_o  (iter_done),
`ifdef ALU_MC_DIV_EN
    .shr_o   (iter_shr),
`endif
    .acc_o   (iter_acc)
  );

  // Controller: accept in IDLE, dispatch to the iterative unit or register a single-cycle result
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    err_d      = err_q;
    vld_d      = 1'b0;
    iter_start = 1'b0;
`ifdef ALU_MC_DIV_EN
    iter_div   = 1'b0;
    rem_sel_d  = rem_sel_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          if (OPRN == OPRN_WIDTH'(ALU_OP_MUL)) begin
            iter_start = 1'b1;
            state_d    = ST_MUL;
          end
`ifdef ALU_MC_DIV_EN
          else if (is_divu || is_remu) begin
            if (OP2 == '0) begin
              // Divide by zero resolves immediately: quotient saturates, remainder is the dividend
              out_d = is_remu ? OP1 : '1;
              err_d = 1'b1;
              vld_d = 1'b1;
            end else begin
              iter_start = 1'b1;
              iter_div   = 1'b1;
              rem_sel_d  = is_remu;
              state_d    = ST_DIV;
            end
          end
`endif
          else begin
            out_d = sc_res;
            err_d = sc_err;
            vld_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (iter_done) begin
          out_d   = iter_acc;
          err_d   = 1'b0;
          vld_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
`ifdef ALU_MC_DIV_EN
      ST_DIV: begin
        if (iter_done) begin
          out_d   = rem_sel_q ? iter_acc : iter_shr;
          err_d   = 1'b0;
          vld_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Flags follow the value being registered; they only move when OUT does
  assign zero_d = (out_d == '0);
  assign neg_d  = out_d[DATA_WIDTH-1];

  // State and result registers; reset aborts any iterative op with no result pulse
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      out_q     <= '0;
      zero_q    <= 1'b1;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
      vld_q     <= 1'b0;
`ifdef ALU_MC_DIV_EN
      rem_sel_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      zero_q    <= zero_d;
      neg_q     <= neg_d;
      err_q     <= err_d;
      vld_q     <= vld_d;
`ifdef ALU_MC_DIV_EN
      rem_sel_q <= rem_sel_d;
`endif
    end
  end

  assign IN_READY  = (state_q == ST_IDLE) && !iter_busy;
  assign OUT_VALID = vld_q;
  assign OUT       = out_q;
  assign ZERO      = zero_q;
  assign NEG       = neg_q;
  assign ERR       = err_q;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, registered, multi-cycle successor to the processor's combinational ALU.
- Accepts one operation per handshake. Simple ops complete in one cycle; multiply is an iterative shift-add over DATA_WIDTH cycles.
- Produces a registered result plus ZERO, NEG and ERR status flags.
- Sits between the control unit and the register file/data path. The control unit stalls on IN_READY.

Parameters:
- DATA_WIDTH, 32, operand/result width; ≥ 4, power of 2.
- OPRN_WIDTH, 6, operation-code width.
- SHAMT_WIDTH, $clog2(DATA_WIDTH), width of the shift-amount field taken from OP2.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  operation request.
- IN_READY  out  1  block can accept a request this cycle.
- OP1  in  DATA_WIDTH  operand 1.
- OP2  in  DATA_WIDTH  operand 2.
- OPRN  in  OPRN_WIDTH  operation code.
- OUT_VALID  out  1  one-cycle pulse: OUT/flags updated.
- OUT  out  DATA_WIDTH  result; holds until the next OUT_VALID.
- ZERO  out  1  OUT == 0.
- NEG  out  1  OUT[DATA_WIDTH-1].
- ERR  out  1  unsupported opcode (or divide by zero, see feature).

Behaviour:
- Reset (RST=0, async): state IDLE, OUT=0, ZERO=1, NEG=0, ERR=0, OUT_VALID=0, IN_READY=1. Reset mid-multiply aborts the operation with no OUT_VALID.
- Accept: a request is taken when IN_VALID && IN_READY at a rising edge. Operands and opcode are captured internally, so OP1/OP2/OPRN may change afterwards.
- FSM states:
  - IDLE: IN_READY=1. A single-cycle op computes and registers OUT, with OUT_VALID=1 the next cycle; stays in IDLE, so back-to-back single-cycle ops sustain 1 per cycle. Opcode 0x2c goes to MUL.
  - MUL: IN_READY=0. Counter runs 0..DATA_WIDTH-1. Each cycle: if multiplier LSB is set, acc += multiplicand; then multiplicand <<= 1 and multiplier >>= 1. After DATA_WIDTH cycles, OUT = acc (low DATA_WIDTH bits; overflow discarded) and OUT_VALID pulses. Go to IDLE. Latency from accept to OUT_VALID: DATA_WIDTH+1 cycles.
  - (DIV: see Optional Feature.)
- Opcodes:
  - 0x20 add, 0x22 sub: modulo 2^DATA_WIDTH, no overflow flag.
  - 0x2c mul: as in MUL state.
  - 0x02 srl, 0x01 sll: logical shifts. If OP2 ≥ DATA_WIDTH, result 0; otherwise shift by OP2[SHAMT_WIDTH-1:0].
  - 0x24 and, 0x25 or, 0x27 nor.
  - 0x2a slt: signed compare, result 1/0 zero-extended.
  - 0x2b sltu: unsigned compare.
- Unsupported opcode: OUT=0, ERR=1, OUT_VALID pulses after 1 cycle.
- Flags: ERR=0 for any valid op. ZERO, NEG and ERR update only together with OUT_VALID.
- IN_VALID while IN_READY=0 is ignored; the requester must hold the request until accepted.

Optional Feature:
- Macro: ALU_MC_DIV_EN.
- Defined:
  - Opcodes 0x1a (divu → quotient) and 0x1b (remu → remainder) enter DIV state.
  - DIV state: unsigned restoring division over DATA_WIDTH cycles, same latency as MUL, IN_READY=0 throughout.
  - Divide by zero: completes in 1 cycle with OUT = all ones (0x1a) or OP1 (0x1b), ERR=1.
- Undefined:
  - No DIV state or divider logic.
  - 0x1a and 0x1b are treated as unsupported opcodes (OUT=0, ERR=1).

Decomposition:
- Shared definitions header alongside prj_definition.v: opcode constants (ALU_OP_ADD, ALU_OP_SUB, ALU_OP_MUL, ALU_OP_SRL, ALU_OP_SLL, ALU_OP_AND, ALU_OP_OR, ALU_OP_NOR, ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_DIVU, ALU_OP_REMU) and FSM state encodings.
- One sub-module, alu_mc_iter: shared shift/accumulate datapath for multiply and divide, with start/busy/done.
- Single-cycle ops stay inline in alu_mc.

Test Plan:
- Reset during MUL (RST low 1 cycle) → OUT=0, ZERO=1, IN_READY=1 asynchronously; no OUT_VALID afterwards.
- Back-to-back add 7+5, sub 5−7, nor 0,0 on consecutive cycles → OUT_VALID 3 consecutive cycles:
  - OUT=12
  - OUT=0xFFFFFFFE with NEG=1
  - OUT=0xFFFFFFFF
- mul 0x10000 × 0x10001 → IN_READY low 32 cycles, OUT_VALID at cycle 33, OUT=0x00010000 (upper bits dropped). IN_VALID asserted during MUL is not accepted.
- slt 0xFFFFFFFF, 1 → 1; sltu same operands → 0 with ZERO=1.
- sll 1, 32 → OUT=0, ZERO=1; srl 0x80000000, 31 → OUT=1.
- Opcode 0x3f → OUT=0, ERR=1. With ALU_MC_DIV_EN: divu 100,7 → 14 and remu → 2 (latency 33); divu x,0 → 0xFFFFFFFF, ERR=1.
